// File: rtl/via_out_arbiter.sv
// via_out_arbiter: round-robin share of one NoC injection port among
// NUM_REQ sources, holding each grant for a PKT_LEN-beat packet.
module via_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int PKT_LEN      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*WIDTH-1:0]        req_data_in,
  input  logic [NUM_REQ*N_ADDR_WIDTH-1:0] req_dest_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  output logic [WIDTH-1:0]                out_data_out,
  output logic [N_ADDR_WIDTH-1:0]         out_dest_out,
  output logic                            out_valid_out,
  input  logic                            out_ready_in,
  output logic [NUM_REQ-1:0]              grant_out,
  output logic                            locked_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
  localparam logic [PW-1:0] TOP  = PW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [CW-1:0]           cnt;
  logic [NUM_REQ-1:0]      lock_gnt;
  logic [NUM_REQ-1:0]      rr_gnt;
  logic [PW-1:0]           gidx;
  logic [PW-1:0]           nxt_ptr;
  logic                    found;
  logic                    free;
  logic                    accept;
  logic [WIDTH-1:0]        sel_data;
  logic [N_ADDR_WIDTH-1:0] sel_dest;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    rr_gnt = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_in[i] &&
            ((int'(ptr) + k) % NUM_REQ) == i) begin
          rr_gnt[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_out = '0;
    if (rst) begin
      grant_out = (state == LOCKED) ? lock_gnt : rr_gnt;
    end
  end

  assign free          = !out_valid_out || out_ready_in;
  assign req_ready_out = grant_out & {NUM_REQ{free}};
  assign accept        = |(req_ready_out & req_valid_in);

  always_comb begin
    gidx     = '0;
    sel_data = '0;
    sel_dest = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_out[i]) begin
        gidx     = PW'(i);
        sel_data = req_data_in[i*WIDTH +: WIDTH];
        sel_dest = req_dest_in[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
      end
    end
  end

  assign nxt_ptr = (gidx == TOP) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_out <= 1'b0;
      out_data_out  <= '0;
      out_dest_out  <= '0;
      ptr           <= '0;
      cnt           <= '0;
      lock_gnt      <= '0;
      state         <= IDLE;
      locked_out    <= 1'b0;
    end else begin
      if (free) begin
        out_valid_out <= accept;
        if (accept) begin
          out_data_out <= sel_data;
          out_dest_out <= sel_dest;
        end
      end
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (PKT_LEN == 1) begin
              ptr <= nxt_ptr;
            end else begin
              lock_gnt   <= grant_out;
              cnt        <= CW'(1);
              state      <= LOCKED;
              locked_out <= 1'b1;
            end
          end
          LOCKED: begin
            if (cnt == LAST) begin
              ptr        <= nxt_ptr;
              cnt        <= '0;
              state      <= IDLE;
              locked_out <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_via_out_arbiter.sv
// Bench for via_out_arbiter: three configurations against an
// owner/beats-left reference model plus directed literal scenarios.
module tb_via_out_arbiter;

  localparam int NI = 3;
  localparam int W  = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [4*W-1:0]    dat  [NI];
  logic [4*AW-1:0]   dst  [NI];
  logic [3:0]        vld  [NI];
  logic              ordy [NI];
  logic [W-1:0]      od   [NI];
  logic [AW-1:0]     odst [NI];
  logic              ov   [NI];
  logic              lk   [NI];
  logic [3:0]        rdy0, g0, rdy2, g2;
  logic [2:0]        rdy1, g1;
  logic [3:0]        rdy_all [NI];
  logic [3:0]        g_all   [NI];

  via_out_arbiter #(.NUM_REQ(4), .WIDTH(W), .N(16), .PKT_LEN(1)) u_a (
    .clk(clk), .rst(rst_n),
    .req_data_in(dat[0]), .req_dest_in(dst[0]),
    .req_valid_in(vld[0]), .req_ready_out(rdy0),
    .out_data_out(od[0]), .out_dest_out(odst[0]),
    .out_valid_out(ov[0]), .out_ready_in(ordy[0]),
    .grant_out(g0), .locked_out(lk[0]));

  via_out_arbiter #(.NUM_REQ(3), .WIDTH(W), .N(16), .PKT_LEN(3)) u_b (
    .clk(clk), .rst(rst_n),
    .req_data_in(dat[1][3*W-1:0]), .req_dest_in(dst[1][3*AW-1:0]),
    .req_valid_in(vld[1][2:0]), .req_ready_out(rdy1),
    .out_data_out(od[1]), .out_dest_out(odst[1]),
    .out_valid_out(ov[1]), .out_ready_in(ordy[1]),
    .grant_out(g1), .locked_out(lk[1]));

  via_out_arbiter #(.NUM_REQ(4), .WIDTH(W), .N(16), .PKT_LEN(4)) u_c (
    .clk(clk), .rst(rst_n),
    .req_data_in(dat[2]), .req_dest_in(dst[2]),
    .req_valid_in(vld[2]), .req_ready_out(rdy2),
    .out_data_out(od[2]), .out_dest_out(odst[2]),
    .out_valid_out(ov[2]), .out_ready_in(ordy[2]),
    .grant_out(g2), .locked_out(lk[2]));

  always_comb begin
    rdy_all[0] = rdy0;
    rdy_all[1] = {1'b0, rdy1};
    rdy_all[2] = rdy2;
    g_all[0]   = g0;
    g_all[1]   = {1'b0, g1};
    g_all[2]   = g2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int nreq(input int i);
    return (i == 1) ? 3 : 4;
  endfunction

  function automatic int plen(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // Model: owner of the current packet (-1 = none), beats still owed,
  // round-robin start point, and the single output register.
  int           m_ptr  [NI];
  int           m_own  [NI];
  int           m_left [NI];
  logic         m_v    [NI];
  logic [W-1:0] m_d    [NI];
  logic [AW-1:0] m_a   [NI];

  function automatic int pick(input int i);
    int j;
    if (m_own[i] >= 0) return m_own[i];
    for (int k = 0; k < nreq(i); k++) begin
      j = (m_ptr[i] + k) % nreq(i);
      if (vld[i][j]) return j;
    end
    return -1;
  endfunction

  initial begin
    int n, g;
    logic fr, acc;
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_ptr[i] = 0; m_own[i] = -1; m_left[i] = 0;
          m_v[i] = 1'b0; m_d[i] = '0; m_a[i] = '0;
          chk($sformatf("rst_valid[%0d]", i), ov[i], 1'b0);
          chk($sformatf("rst_data[%0d]", i), od[i], '0);
          chk($sformatf("rst_lock[%0d]", i), lk[i], 1'b0);
          chk($sformatf("rst_grant[%0d]", i), g_all[i], 4'b0);
        end else begin
          n  = nreq(i);
          g  = pick(i);
          fr = !m_v[i] || ordy[i];
          eg = (g >= 0) ? 4'(1 << g) : 4'b0;
          chk($sformatf("grant[%0d]", i), g_all[i], eg);
          chk($sformatf("ready[%0d]", i), rdy_all[i], fr ? eg : 4'b0);
          chk($sformatf("lock[%0d]", i), lk[i], m_own[i] >= 0);
          chk($sformatf("valid[%0d]", i), ov[i], m_v[i]);
          if (m_v[i]) begin
            chk($sformatf("data[%0d]", i), od[i], m_d[i]);
            chk($sformatf("dest[%0d]", i), odst[i], m_a[i]);
          end
          acc = (g >= 0) && fr && vld[i][g];
          if (fr) begin
            m_v[i] = acc;
            if (acc) begin
              m_d[i] = dat[i][g*W +: W];
              m_a[i] = dst[i][g*AW +: AW];
            end
          end
          if (acc) begin
            if (m_own[i] < 0) begin
              if (plen(i) == 1) m_ptr[i] = (g + 1) % n;
              else begin
                m_own[i]  = g;
                m_left[i] = plen(i) - 1;
              end
            end else begin
              m_left[i]--;
              if (m_left[i] == 0) begin
                m_own[i] = -1;
                m_ptr[i] = (g + 1) % n;
              end
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int exp_d [6];
  logic exp_l [6];

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      dat[i] = '0; dst[i] = '0; vld[i] = '0; ordy[i] = 1'b1;
    end
    step();
    // Round-robin rotation, PKT_LEN=1
    vld[0] = 4'hF;
    dat[0] = {32'd3, 32'd2, 32'd1, 32'd0};
    dst[0] = {4'd3, 4'd2, 4'd1, 4'd0};
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_seq", od[0], 32'(k % 4));
      chk("rr_dest", odst[0], 4'(k % 4));
      chk("rr_valid", ov[0], 1'b1);
    end
    // Asynchronous reset while a beat is held
    rst_n = 1'b0;
    vld[0] = 4'h0;
    #1;
    chk("async_valid", ov[0], 1'b0);
    chk("async_data", od[0], '0);
    chk("async_grant", g0, 4'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_grant", g0, 4'b0);
      chk("idle_valid", ov[0], 1'b0);
    end
    // Back-pressure: hold for 5 cycles, then resume without bubble
    vld[0] = 4'hF;
    step();
    chk("bp_first", od[0], 32'd0);
    ordy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", od[0], 32'd0);
      chk("bp_ready", rdy0, 4'b0);
    end
    ordy[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bp_resume", od[0], 32'(k));
    end
    vld[0] = 4'h0;

    // Packet lock, PKT_LEN=3, requesters 1 and 2
    vld[1] = 4'b0110;
    dat[1] = {32'd0, 32'd102, 32'd101, 32'd100};
    pulse_reset();
    #1;
    chk("lock_pick", g1, 3'b010);
    exp_d = '{101, 101, 101, 102, 102, 102};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      step();
      chk("lock_seq", od[1], 32'(exp_d[k]));
      chk("lock_flag", lk[1], exp_l[k]);
    end
    vld[1] = 4'b0;

    // Starvation when the owner drops valid, PKT_LEN=4
    vld[2] = 4'b1001;
    dat[2] = {32'd300, 32'd0, 32'd0, 32'd200};
    pulse_reset();
    step();
    step();
    chk("starve_beat2", od[2], 32'd200);
    vld[2] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("starve_grant", g2, 4'b0001);
      chk("starve_rdy3", rdy2[3], 1'b0);
    end
    vld[2] = 4'b1001;
    step();
    chk("starve_lock3", lk[2], 1'b1);
    step();
    chk("starve_unlock", lk[2], 1'b0);
    chk("starve_next", g2, 4'b1000);
    step();
    chk("starve_r3", od[2], 32'd300);
    vld[2] = 4'b0;

    // Wrap with non power-of-2 NUM_REQ, sparse request
    vld[1] = 4'b0010;
    dat[1] = {32'd0, 32'd22, 32'd21, 32'd20};
    pulse_reset();
    repeat (3) step();
    chk("wrap_sparse", g1, 3'b010);
    repeat (3) step();
    chk("wrap_idle", lk[1], 1'b0);
    vld[1] = 4'b0111;
    #1;
    chk("wrap_pick2", g1, 3'b100);
    step();
    vld[1] = 4'b0;

    // Randomized traffic on all three configurations
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        vld[i]  = 4'($urandom_range(0, 15));
        dat[i]  = {$urandom, $urandom, $urandom, $urandom};
        dst[i]  = 16'($urandom);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
